// File: rtl/alu_pipe_if.sv
// Operand-issue and result-consumer handshake bundle for alu_pipe.
// The master side issues operations and accepts results; the slave side is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             busy;

  modport master (
    output in_valid, ctrl, x, y, out_ready,
    input  in_ready, out_valid, out, carry, busy
  );

  modport slave (
    input  in_valid, ctrl, x, y, out_ready,
    output in_ready, out_valid, out, carry, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered parametrised ALU with valid/ready handshakes and an iterative
// shift-add unsigned multiplier (one multiplier bit per cycle).
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_NOT  = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_NOR  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_ROL  = 4'b1010,
    OP_ROR  = 4'b1011,
    OP_EQ   = 4'b1100,
    OP_MUL  = 4'b1101,
    OP_NOP0 = 4'b1110,
    OP_NOP1 = 4'b1111
  } op_e;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e             state_q, state_n;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   out_q;
  logic               carry_q;
  logic               out_valid_q;

  logic               in_ready_c;
  logic               busy_c;
  logic               mul_done;
  logic               accept;
  logic               consume;
  logic               is_mul;
  op_e                op;

  logic [WIDTH-1:0]   res;
  logic               res_carry;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     amt_x;
  logic [SHW-1:0]     amt_y;
  logic [SHW:0]       amt_inv;

  assign op      = op_e'(bus.ctrl);
  assign is_mul  = (op == OP_MUL);
  assign accept  = bus.in_valid & in_ready_c;
  assign consume = out_valid_q & bus.out_ready;
  assign amt_x   = bus.x[SHW-1:0];
  assign amt_y   = bus.y[SHW-1:0];
  // Complementary rotate amount; a shift by WIDTH yields zero, so rotate-by-0 returns x.
  assign amt_inv = (SHW+1)'(WIDTH) - {1'b0, amt_y};
  assign acc_n   = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;

  // Single-cycle result for every opcode except MUL.
  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    sum       = '0;
    case (op)
      OP_ADD: begin
        sum       = {bus.x[WIDTH-1], bus.x} + {bus.y[WIDTH-1], bus.y};
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
      end
      OP_SUB: begin
        sum       = {bus.x[WIDTH-1], bus.x} - {bus.y[WIDTH-1], bus.y};
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
      end
      OP_AND:  res = bus.x & bus.y;
      OP_OR:   res = bus.x | bus.y;
      OP_NOT:  res = ~bus.x;
      OP_XOR:  res = bus.x ^ bus.y;
      OP_NOR:  res = ~(bus.x | bus.y);
      OP_SLL:  res = bus.y << amt_x;
      OP_SRL:  res = bus.y >> amt_x;
      OP_SRA:  res = WIDTH'($signed(bus.x) >>> amt_y);
      OP_ROL:  res = (bus.x << amt_y) | (bus.x >> amt_inv);
      OP_ROR:  res = (bus.x >> amt_y) | (bus.x << amt_inv);
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, (bus.x == bus.y)};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // In MUL the block refuses new work; completion is flagged on the last counter value.
  always_comb begin
    state_n    = state_q;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    mul_done   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = ~out_valid_q | bus.out_ready;
        if (bus.in_valid && in_ready_c && is_mul) begin
          state_n = MUL;
        end
      end
      MUL: begin
        busy_c = 1'b1;
        if (cnt_q == '0) begin
          mul_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (accept && is_mul) begin
      cnt_q    <= CNT_LAST;
      mcand_q  <= {{WIDTH{1'b0}}, bus.x};
      mplier_q <= bus.y;
      acc_q    <= '0;
    end else if (busy_c) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - SHW'(1);
      end
    end
  end

  // A finishing multiply overwrites any pending result; otherwise consume clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept && !is_mul) begin
      out_q       <= res;
      carry_q     <= res_carry;
      out_valid_q <= 1'b1;
    end else if (mul_done) begin
      out_q       <= acc_n[WIDTH-1:0];
      carry_q     <= |acc_n[2*WIDTH-1:WIDTH];
      out_valid_q <= 1'b1;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_alu_pipe;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011;
  localparam logic [3:0] NOT_ = 4'b0100, XOR_ = 4'b0101, NOR_ = 4'b0110, SLL = 4'b0111;
  localparam logic [3:0] SRL = 4'b1000, SRA = 4'b1001, ROL = 4'b1010, ROR = 4'b1011;
  localparam logic [3:0] EQ = 4'b1100, MUL = 4'b1101, NOP = 4'b1110;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8))  bus8 ();
  alu_pipe_if #(.WIDTH(16)) bus16 ();

  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.ctrl     = op;
    bus8.x        = a;
    bus8.y        = b;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic applyStimulusWide(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus16.ctrl     = op;
    bus16.x        = a;
    bus16.y        = b;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
  endtask

  // Counts busy cycles while scrambling inputs, then checks the product.
  task automatic waitMul8(input string tag, input logic [7:0] exp_out, input logic exp_carry);
    int n = 0;
    while (bus8.busy === 1'b1 && n < 40) begin
      n++;
      checkOutput({tag, " in_ready low"}, {31'd0, bus8.in_ready}, 32'd0);
      bus8.x        = 8'($urandom);
      bus8.y        = 8'($urandom);
      bus8.ctrl     = 4'($urandom);
      bus8.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus8.in_valid = 1'b0;
    checkOutput({tag, " busy cycles"}, 32'(n), 32'd8);
    checkOutput({tag, " out_valid"}, {31'd0, bus8.out_valid}, 32'd1);
    checkOutput({tag, " out"}, {24'd0, bus8.out}, {24'd0, exp_out});
    checkOutput({tag, " carry"}, {31'd0, bus8.carry}, {31'd0, exp_carry});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.ctrl = '0;  bus8.x = '0;  bus8.y = '0;  bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.ctrl = '0; bus16.x = '0; bus16.y = '0; bus16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'd0, bus8.out_valid}, 32'd0);
    checkOutput("reset out", {24'd0, bus8.out}, 32'd0);
    checkOutput("reset busy", {31'd0, bus8.busy}, 32'd0);
    rst = 1'b0;

    $display("[TB] reset during multiply");
    applyStimulus(MUL, 8'hFF, 8'hFF);
    checkOutput("mul start busy", {31'd0, bus8.busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-reset out_valid", {31'd0, bus8.out_valid}, 32'd0);
    checkOutput("post-reset out", {24'd0, bus8.out}, 32'd0);
    checkOutput("post-reset busy", {31'd0, bus8.busy}, 32'd0);
    checkOutput("post-reset in_ready", {31'd0, bus8.in_ready}, 32'd1);
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid === 1'b1) n++;
    end
    checkOutput("abandoned mul no result", 32'(n), 32'd0);

    $display("[TB] add and subtract");
    applyStimulus(ADD, 8'h2B, 8'hA7);
    checkOutput("add out_valid", {31'd0, bus8.out_valid}, 32'd1);
    checkOutput("add out", {24'd0, bus8.out}, 32'hD2);
    checkOutput("add carry", {31'd0, bus8.carry}, 32'd1);
    applyStimulus(SUB, 8'hAC, 8'h17);
    checkOutput("sub out", {24'd0, bus8.out}, 32'h95);
    checkOutput("sub carry", {31'd0, bus8.carry}, 32'd1);

    $display("[TB] back-to-back stream");
    vecs.push_back('{ROL,  8'hA9, 8'h03, 8'h4D, 1'b0});
    vecs.push_back('{ROR,  8'hA9, 8'h03, 8'h35, 1'b0});
    vecs.push_back('{SRA,  8'h84, 8'h02, 8'hE1, 1'b0});
    vecs.push_back('{SLL,  8'h05, 8'h5A, 8'h40, 1'b0});
    vecs.push_back('{AND_, 8'hA5, 8'h3C, 8'h24, 1'b0});
    vecs.push_back('{OR_,  8'hA5, 8'h3C, 8'hBD, 1'b0});
    vecs.push_back('{NOT_, 8'hA5, 8'h3C, 8'h5A, 1'b0});
    vecs.push_back('{NOR_, 8'hA5, 8'h3C, 8'h42, 1'b0});
    vecs.push_back('{SRL,  8'h03, 8'hB4, 8'h16, 1'b0});
    vecs.push_back('{SRA,  8'h84, 8'h00, 8'h84, 1'b0});
    vecs.push_back('{ROL,  8'hA9, 8'h00, 8'hA9, 1'b0});
    vecs.push_back('{EQ,   8'h12, 8'h13, 8'h00, 1'b0});
    vecs.push_back('{NOP,  8'hFF, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{ADD,  8'h7F, 8'h01, 8'h80, 1'b0});
    vecs.push_back('{SUB,  8'h00, 8'h01, 8'hFF, 1'b1});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("stream%0d out_valid", i), {31'd0, bus8.out_valid}, 32'd1);
      checkOutput($sformatf("stream%0d out", i), {24'd0, bus8.out}, {24'd0, vecs[i].res});
      checkOutput($sformatf("stream%0d carry", i), {31'd0, bus8.carry}, {31'd0, vecs[i].c});
    end
    @(posedge clk);
    #1;
    checkOutput("consume clears out_valid", {31'd0, bus8.out_valid}, 32'd0);

    $display("[TB] multiply");
    applyStimulus(MUL, 8'h0D, 8'h0B);
    waitMul8("mul 0d*0b", 8'h8F, 1'b0);
    applyStimulus(MUL, 8'h10, 8'h10);
    waitMul8("mul 10*10", 8'h00, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(XOR_, 8'h84, 8'hAE);
    checkOutput("xor out", {24'd0, bus8.out}, 32'h2A);
    bus8.out_ready = 1'b0;
    bus8.ctrl      = ADD;
    bus8.x         = 8'h01;
    bus8.y         = 8'h01;
    bus8.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d out", i), {24'd0, bus8.out}, 32'h2A);
      checkOutput($sformatf("stall%0d out_valid", i), {31'd0, bus8.out_valid}, 32'd1);
      checkOutput($sformatf("stall%0d in_ready", i), {31'd0, bus8.in_ready}, 32'd0);
    end
    bus8.out_ready = 1'b1;
    applyStimulus(EQ, 8'hA9, 8'hA9);
    checkOutput("eq after stall out", {24'd0, bus8.out}, 32'h01);
    checkOutput("eq after stall out_valid", {31'd0, bus8.out_valid}, 32'd1);

    $display("[TB] WIDTH=16");
    applyStimulusWide(ROL, 16'h8001, 16'h000F);
    checkOutput("w16 rol out", {16'd0, bus16.out}, 32'hC000);
    applyStimulusWide(MUL, 16'h0100, 16'h0100);
    n = 0;
    while (bus16.busy === 1'b1 && n < 60) begin
      n++;
      checkOutput("w16 mul in_ready low", {31'd0, bus16.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("w16 mul busy cycles", 32'(n), 32'd16);
    checkOutput("w16 mul out_valid", {31'd0, bus16.out_valid}, 32'd1);
    checkOutput("w16 mul out", {16'd0, bus16.out}, 32'd0);
    checkOutput("w16 mul carry", {31'd0, bus16.carry}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
